cache_perf_counter_bank: RTL and testbench

Parametrised performance-counter bank for the L1 cache. It replaces fixed 32-bit single-pulse counters with NUM_CH channels, each accepting a multi-count increment per cycle. It adds a global freeze, synchronous clear, an atomic snapshot into shadow registers, a registered read port, and sticky per-channel overflow flags with selectable saturate/wrap mode. It sits beside the cache controller, and its read port feeds the debug/CSR interface.

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_counter_cell.sv | 62 ++++++
 rtl/cache_perf_counter_bank.sv | 100 ++++++++++
 tb/tb_cache_perf_counter_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perf_pkg: shared constants and types for the L1 perf-counter bank    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package perf_pkg;

  localparam int PERF_MAX_CH = 32;

  typedef enum logic {
    PERF_WRAP = 1'b0,
    PERF_SAT  = 1'b1
  } perf_mode_e;

  // L1 event channel assignment
  localparam int CH_HIT         = 0;
  localparam int CH_MISS        = 1;
  localparam int CH_EVICT       = 2;
  localparam int CH_DIRTY_EVICT = 3;
  localparam int CH_PRED_HIT    = 4;
  localparam int CH_PRED_MISS   = 5;
  localparam int CH_STALE       = 6;

endpackage
`default_nettype wire

// File: rtl/perf_counter_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perf_counter_cell: one channel - live counter, shadow, sticky ovf    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int         CNT_W = 32,
  parameter int         INC_W = 2,
  parameter perf_mode_e MODE  = PERF_SAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] inc,
  input  logic             count_en,
  input  logic             clear,
  input  logic             snapshot,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);

  logic [CNT_W-1:0] r_live;
  logic [CNT_W-1:0] r_shadow;
  logic             r_ovf;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_ovf_val;
  logic             w_inc_act;

  assign w_sum     = {1'b0, r_live} + {{(CNT_W+1-INC_W){1'b0}}, inc};
  assign w_inc_act = count_en && (inc != '0);
  // A saturated counter re-carries on every further increment, so it pins at all-ones.
  assign w_ovf_val = (MODE == PERF_SAT) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (snapshot) begin
        r_shadow <= r_live;
      end
      if (clear) begin
        r_live <= '0;
        r_ovf  <= 1'b0;
      end else if (w_inc_act) begin
        if (w_sum[CNT_W]) begin
          r_live <= w_ovf_val;
          r_ovf  <= 1'b1;
        end else begin
          r_live <= w_sum[CNT_W-1:0];
        end
      end
    end
  end

  assign shadow = r_shadow;
  assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: rtl/cache_perf_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_perf_counter_bank: NUM_CH L1 event counters, snapshot, read    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cache_perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH   = 7,
  parameter int CNT_W    = 32,
  parameter int INC_W    = 2,
  parameter int SATURATE = 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NUM_CH*INC_W-1:0]                         inc,
  input  logic                                            count_en,
  input  logic                                            clear,
  input  logic                                            snapshot,
  input  logic                                            rd_req,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  rd_sel,
  output logic                                            rd_valid,
  output logic [CNT_W-1:0]                                rd_data,
  output logic                                            rd_err,
  output logic [NUM_CH-1:0]                               ovf,
  output logic                                            ovf_any
);

  localparam int         SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam perf_mode_e MODE  = (SATURATE != 0) ? PERF_SAT : PERF_WRAP;

  logic [CNT_W-1:0] w_shadow [NUM_CH];
  logic [31:0]      w_sel_idx;
  logic [CNT_W-1:0] w_sel_data;
  logic             w_sel_err;

  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_rd_err;
  logic             r_ovf_any;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      perf_counter_cell #(
        .CNT_W (CNT_W),
        .INC_W (INC_W),
        .MODE  (MODE)
      ) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc[i*INC_W +: INC_W]),
        .count_en (count_en),
        .clear    (clear),
        .snapshot (snapshot),
        .shadow   (w_shadow[i]),
        .ovf      (ovf[i])
      );
    end
  endgenerate

  assign w_sel_idx = {{(32-SEL_W){1'b0}}, rd_sel};

  // Out-of-range selects match no channel, so the data stays zero alongside rd_err.
  always_comb begin
    w_sel_data = '0;
    w_sel_err  = (w_sel_idx >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel_idx == i) begin
        w_sel_data = w_shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
      r_ovf_any  <= 1'b0;
    end else begin
      r_ovf_any <= |ovf;
      if (rd_req) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_sel_data;
        r_rd_err   <= w_sel_err;
      end else begin
        r_rd_valid <= 1'b0;
        r_rd_data  <= '0;
        r_rd_err   <= 1'b0;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_err   = r_rd_err;
  assign ovf_any  = r_ovf_any;

endmodule
`default_nettype wire

// File: tb/tb_cache_perf_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_perf_counter_bank: wrap and saturate banks, shared stimulus |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cache_perf_counter_bank;
  import perf_pkg::*;

  localparam int NUM_CH = 7;
  localparam int CNT_W  = 8;
  localparam int INC_W  = 2;

  typedef struct packed {
    logic       err;
    logic [7:0] dw;
    logic [7:0] ds;
  } sb_t;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH*INC_W-1:0] inc;
  logic                    count_en;
  logic                    clear;
  logic                    snapshot;
  logic                    rd_req;
  logic [2:0]              rd_sel;

  // index 0 = wrap bank, index 1 = saturating bank
  logic              rv   [2];
  logic [CNT_W-1:0]  rdat [2];
  logic              re   [2];
  logic [NUM_CH-1:0] ov   [2];
  logic              oa   [2];

  int checks;
  int failures;

  sb_t sb_q [$];
  sb_t pend;

  int                live      [2][NUM_CH];
  logic [NUM_CH-1:0] m_ovf     [2];
  logic              m_ovf_any [2];

  cache_perf_counter_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .INC_W(INC_W), .SATURATE(0)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .inc(inc), .count_en(count_en), .clear(clear),
    .snapshot(snapshot), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv[0]), .rd_data(rdat[0]), .rd_err(re[0]), .ovf(ov[0]), .ovf_any(oa[0])
  );

  cache_perf_counter_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .INC_W(INC_W), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .inc(inc), .count_en(count_en), .clear(clear),
    .snapshot(snapshot), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv[1]), .rd_data(rdat[1]), .rd_err(re[1]), .ovf(ov[1]), .ovf_any(oa[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ovf[m]     = '0;
      m_ovf_any[m] = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) live[m][ch] = 0;
    end
  endtask

  // Reference for live counts and overflow flags; read data comes from directed constants.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      m_ovf_any[m] = |m_ovf[m];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        int a;
        int s;
        a = int'(inc[ch*INC_W +: INC_W]);
        if (clear) begin
          live[m][ch]  = 0;
          m_ovf[m][ch] = 1'b0;
        end else if (count_en && a != 0) begin
          s = live[m][ch] + a;
          if (s > 255) begin
            m_ovf[m][ch] = 1'b1;
            live[m][ch]  = (m == 1) ? 255 : s - 256;
          end else begin
            live[m][ch] = s;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    sb_t  e;
    logic ev;
    string nm;
    if (sb_q.size() != 0) begin
      e  = sb_q.pop_front();
      ev = 1'b1;
    end else begin
      e  = '0;
      ev = 1'b0;
    end
    for (int m = 0; m < 2; m++) begin
      nm = (m == 1) ? "sat" : "wrap";
      chk({"rd_valid_", nm}, 32'(rv[m]), 32'(ev));
      chk({"rd_err_", nm}, 32'(re[m]), 32'(e.err));
      chk({"rd_data_", nm}, 32'(rdat[m]), (m == 1) ? 32'(e.ds) : 32'(e.dw));
      chk({"ovf_", nm}, 32'(ov[m]), 32'(m_ovf[m]));
      chk({"ovf_any_", nm}, 32'(oa[m]), 32'(m_ovf_any[m]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      sb_q.delete();
    end else begin
      if (rd_req) sb_q.push_back(pend);
      model_step();
    end
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_inc(input int ch, input int v);
    inc[ch*INC_W +: INC_W] = INC_W'(v);
  endtask

  task automatic rd(input int sel, input int ew, input int es);
    rd_req   = 1'b1;
    rd_sel   = 3'(sel);
    pend.err = (sel >= NUM_CH);
    pend.dw  = 8'(ew);
    pend.ds  = 8'(es);
    cycle();
    rd_req = 1'b0;
  endtask

  task automatic pulse_snapshot();
    snapshot = 1'b1;
    cycle();
    snapshot = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    inc      = '0;
    count_en = 1'b0;
    clear    = 1'b0;
    snapshot = 1'b0;
    rd_req   = 1'b0;
    rd_sel   = '0;
    pend     = '0;
    model_reset();

    // reset state
    run(3);
    rst_n    = 1'b1;
    count_en = 1'b1;
    run(1);

    // basic counting
    set_inc(CH_HIT, 1);
    run(10);
    set_inc(CH_HIT, 0);
    set_inc(CH_DIRTY_EVICT, 3);
    run(4);
    set_inc(CH_DIRTY_EVICT, 0);
    pulse_snapshot();
    rd(CH_HIT, 10, 10);
    run(1);
    rd(CH_DIRTY_EVICT, 12, 12);
    run(1);

    // saturation / wrap over 90 increments of 3
    pulse_clear();
    set_inc(CH_MISS, 3);
    run(90);
    set_inc(CH_MISS, 0);
    run(2);
    pulse_snapshot();
    rd(CH_MISS, 14, 255);

    // wrap from 254
    pulse_clear();
    set_inc(CH_EVICT, 3);
    run(84);
    set_inc(CH_EVICT, 2);
    run(1);
    set_inc(CH_EVICT, 3);
    run(1);
    set_inc(CH_EVICT, 0);
    pulse_snapshot();
    rd(CH_EVICT, 1, 255);
    pulse_clear();
    pulse_snapshot();
    rd(CH_EVICT, 0, 0);

    // increment + clear + snapshot in the same cycle
    set_inc(CH_HIT, 2);
    run(25);
    clear    = 1'b1;
    snapshot = 1'b1;
    cycle();
    clear    = 1'b0;
    snapshot = 1'b0;
    set_inc(CH_HIT, 0);
    rd(CH_HIT, 50, 50);
    count_en = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) set_inc(ch, 3);
    run(5);
    inc      = '0;
    count_en = 1'b1;
    pulse_snapshot();
    rd(CH_HIT, 0, 0);

    // read edge cases
    rd(7, 0, 0);
    set_inc(CH_PRED_HIT, 1);
    run(3);
    set_inc(CH_PRED_HIT, 0);
    snapshot = 1'b1;
    rd(CH_PRED_HIT, 0, 0);
    snapshot = 1'b0;
    rd(CH_PRED_HIT, 3, 3);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rd(ch, (ch == CH_PRED_HIT) ? 3 : 0, (ch == CH_PRED_HIT) ? 3 : 0);
    end
    run(1);

    // async reset mid-count, with ovf set and a read in flight
    set_inc(CH_PRED_MISS, 3);
    set_inc(CH_STALE, 3);
    run(33);
    set_inc(CH_PRED_MISS, 1);
    run(1);
    set_inc(CH_PRED_MISS, 0);
    run(52);
    set_inc(CH_STALE, 0);
    run(1);
    rd(CH_PRED_MISS, 0, 0);
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async_rd_valid", 32'(rv[m]), 32'd0);
      chk("async_rd_data", 32'(rdat[m]), 32'd0);
      chk("async_rd_err", 32'(re[m]), 32'd0);
      chk("async_ovf", 32'(ov[m]), 32'd0);
      chk("async_ovf_any", 32'(oa[m]), 32'd0);
    end
    model_reset();
    sb_q.delete();
    cycle();
    rst_n = 1'b1;
    set_inc(CH_PRED_MISS, 1);
    run(4);
    set_inc(CH_PRED_MISS, 0);
    pulse_snapshot();
    rd(CH_PRED_MISS, 4, 4);
    rd(CH_STALE, 0, 0);
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
